rf_write_arbiter: RTL

//  Owns the single write port of the 16x16 register file. Requesters (ALU

---
 rtl/rf_write_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/rf_write_arbiter.sv
// Single write port of the register file: round-robin grant across N_REQ
// valid/ready requesters, registered RF write, and a zeroing sequence for r1..r15.
module rf_write_arbiter #(
    parameter int N_REQ = 3,
    parameter int AW    = 4,
    parameter int DW    = 16
) (
    input  logic                CLK,
    input  logic                RSTBAR,
    input  logic                CLR_REQ,
    output logic                CLR_BUSY,
    input  logic [N_REQ-1:0]    REQ_VALID,
    input  logic [N_REQ*AW-1:0] REQ_ADDR,
    input  logic [N_REQ*DW-1:0] REQ_DATA,
    output logic [N_REQ-1:0]    REQ_READY,
    output logic                WEBAR,
    output logic [AW-1:0]       WA,
    output logic [DW-1:0]       WD,
    output logic [1:0]          GRANT_ID,
    output logic                DIS_WR
);

    typedef enum logic {ST_ARB, ST_CLEAR} state_t;

    localparam logic [AW-1:0] LAST_REG = '1;

    state_t          r_state, w_state_nxt;
    logic [1:0]      r_ptr, w_ptr_nxt;
    logic            r_webar, w_webar_nxt;
    logic [AW-1:0]   r_wa, w_wa_nxt;
    logic [DW-1:0]   r_wd, w_wd_nxt;
    logic [1:0]      r_gid, w_gid_nxt;

    logic            w_gnt_vld;
    logic [1:0]      w_gnt_idx;
    logic            w_arb_open;
    logic [AW-1:0]   w_gnt_addr;
    logic [DW-1:0]   w_gnt_data;
    logic [N_REQ-1:0] w_ready;

    function automatic logic [1:0] rr_idx(input logic [1:0] p, input int off);
        return 2'((int'(p) + off) % N_REQ);
    endfunction

    // Walk from farthest to nearest so the requester right after ptr wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        for (int off = N_REQ; off >= 1; off--) begin
            if (REQ_VALID[rr_idx(r_ptr, off)]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = rr_idx(r_ptr, off);
            end
        end
    end

    assign w_arb_open = (r_state == ST_ARB) && !CLR_REQ;
    assign w_gnt_addr = REQ_ADDR[w_gnt_idx*AW +: AW];
    assign w_gnt_data = REQ_DATA[w_gnt_idx*DW +: DW];

    always_comb begin
        w_ready = '0;
        if (w_arb_open && w_gnt_vld)
            w_ready[w_gnt_idx] = 1'b1;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_webar_nxt = 1'b1;
        w_wa_nxt    = r_wa;
        w_wd_nxt    = r_wd;
        w_gid_nxt   = r_gid;
        case (r_state)
            ST_ARB: begin
                if (CLR_REQ) begin
                    w_state_nxt = ST_CLEAR;
                    w_webar_nxt = 1'b0;
                    w_wa_nxt    = AW'(1);
                    w_wd_nxt    = '0;
                end else if (w_gnt_vld) begin
                    w_ptr_nxt = w_gnt_idx;
                    w_gid_nxt = w_gnt_idx;
                    // r0 is hardwired: accept the offer but never drive the port.
                    if (w_gnt_addr != '0) begin
                        w_webar_nxt = 1'b0;
                        w_wa_nxt    = w_gnt_addr;
                        w_wd_nxt    = w_gnt_data;
                    end
                end
            end
            ST_CLEAR: begin
                if (r_wa == LAST_REG) begin
                    w_state_nxt = ST_ARB;
                end else begin
                    w_webar_nxt = 1'b0;
                    w_wa_nxt    = r_wa + AW'(1);
                    w_wd_nxt    = '0;
                end
            end
            default: w_state_nxt = ST_ARB;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTBAR) begin
        if (!RSTBAR) begin
            r_state <= ST_ARB;
            r_ptr   <= 2'(N_REQ - 1);
            r_webar <= 1'b1;
            r_wa    <= '0;
            r_wd    <= '0;
            r_gid   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_webar <= w_webar_nxt;
            r_wa    <= w_wa_nxt;
            r_wd    <= w_wd_nxt;
            r_gid   <= w_gid_nxt;
        end
    end

    assign REQ_READY = w_ready;
    assign CLR_BUSY  = (r_state == ST_CLEAR);
    assign WEBAR     = r_webar;
    assign WA        = r_wa;
    assign WD        = r_wd;
    assign GRANT_ID  = r_gid;
    assign DIS_WR    = !r_webar && (r_wa == LAST_REG);

endmodule
